// File: rtl/insn_field_packer.sv
// insn_field_packer
// Two-stage pipeline that narrows a 32-bit value into one of three
// instruction field formats and packs it with opcode/rd/rs.
// S1 holds the request plus its range-check verdict.
// S2 holds the packed word presented downstream.
// A saturating counter tallies errored words actually delivered.
module insn_field_packer #(
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [4:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs,
    input  logic [31:0]      in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_insn,
    output logic             out_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] KIND_IMM17 = 2'd0;
    localparam logic [1:0] KIND_TGT27 = 2'd1;
    localparam logic [1:0] KIND_PC12  = 2'd2;

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    // Does the value fit the selected field? Kind 3 never fits.
    function automatic logic value_fits(input logic [1:0] kind, input logic [31:0] value);
        logic fit;
        case (kind)
            KIND_IMM17: fit = (&value[31:16]) | (~|value[31:16]);
            KIND_TGT27: fit = ~|value[31:27];
            KIND_PC12:  fit = ~|value[31:12];
            default:    fit = 1'b0;
        endcase
        return fit;
    endfunction

    // Build the instruction word; out-of-range values keep their low bits.
    function automatic logic [31:0] pack_word(input logic [1:0]  kind,
                                              input logic [4:0]  opcode,
                                              input logic [4:0]  rd,
                                              input logic [4:0]  rs,
                                              input logic [31:0] value);
        logic [31:0] word;
        case (kind)
            KIND_IMM17: word = {opcode, rd, rs, value[16:0]};
            KIND_TGT27: word = {opcode, value[26:0]};
            KIND_PC12:  word = {opcode, rd, rs, 5'b00000, value[11:0]};
            default:    word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    // Stage 1 registers
    logic        r_s1_valid;
    logic        r_s1_err;
    logic [1:0]  r_s1_kind;
    logic [4:0]  r_s1_opcode;
    logic [4:0]  r_s1_rd;
    logic [4:0]  r_s1_rs;
    logic [31:0] r_s1_value;

    // Stage 2 registers (drive the outputs directly)
    logic             r_s2_valid;
    logic [31:0]      r_out_insn;
    logic             r_out_err;
    logic [ERR_W-1:0] r_err_count;

    // Handshake wires
    logic        w_s2_adv;
    logic        w_s1_load;
    logic        w_out_xfer;
    logic [31:0] w_packed;

    // Stage advance conditions: S2 moves when empty or drained, S1 when
    // empty or emptying into S2.
    always_comb begin
        w_s2_adv   = 1'b0;
        w_s1_load  = 1'b0;
        w_out_xfer = 1'b0;
        if (!r_s2_valid || out_ready) begin
            w_s2_adv = 1'b1;
        end else begin
            w_s2_adv = 1'b0;
        end
        if (!r_s1_valid || w_s2_adv) begin
            w_s1_load = 1'b1;
        end else begin
            w_s1_load = 1'b0;
        end
        if (r_s2_valid && out_ready) begin
            w_out_xfer = 1'b1;
        end else begin
            w_out_xfer = 1'b0;
        end
    end

    // Pack the word held in S1 so S2 can capture it.
    always_comb begin
        w_packed = 32'h0000_0000;
        if (r_s1_valid) begin
            w_packed = pack_word(r_s1_kind, r_s1_opcode, r_s1_rd, r_s1_rs, r_s1_value);
        end else begin
            w_packed = 32'h0000_0000;
        end
    end

    // Stage 1: capture request fields and the range-check verdict.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_err    <= 1'b0;
            r_s1_kind   <= 2'd0;
            r_s1_opcode <= 5'd0;
            r_s1_rd     <= 5'd0;
            r_s1_rs     <= 5'd0;
            r_s1_value  <= 32'h0000_0000;
        end else if (w_s1_load) begin
            r_s1_valid  <= in_valid;
            r_s1_err    <= ~value_fits(in_kind, in_value);
            r_s1_kind   <= in_kind;
            r_s1_opcode <= in_opcode;
            r_s1_rd     <= in_rd;
            r_s1_rs     <= in_rs;
            r_s1_value  <= in_value;
        end
    end

    // Stage 2: hold the packed word; error flag only rides with a valid word.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_out_insn <= 32'h0000_0000;
            r_out_err  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_out_insn <= w_packed;
            r_out_err  <= r_s1_valid & r_s1_err;
        end
    end

    // Saturating count of errored words handed downstream.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_err_count <= {ERR_W{1'b0}};
        end else if (w_out_xfer && r_out_err && (r_err_count != ERR_MAX)) begin
            r_err_count <= r_err_count + ERR_ONE;
        end
    end

    // While reset is held the pipeline is treated as empty.
    assign in_ready  = (~reset_n) | w_s1_load;
    assign out_valid = r_s2_valid;
    assign out_insn  = r_out_insn;
    assign out_err   = r_out_err;
    assign err_count = r_err_count;

endmodule
